// File: rtl/fb_scanout_if.sv
// fb_scanout_if: synchronous framebuffer read port.
//   read_addr : word address driven by the scanout engine (master)
//   read_data : 1-bit pixel returned by the framebuffer (slave) a fixed
//               number of cycles after read_addr changes
interface fb_scanout_if #(
    parameter int ADDR_WIDTH = 15
);
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  read_data;

    modport master (output read_addr, input  read_data);
    modport slave  (input  read_addr, output read_data);
endinterface

// File: rtl/fb_scanout.sv
// fb_scanout: read side of the 160x120 monochrome framebuffer.
// Generates 640x480@60 VGA timing and upscales every stored pixel 4x4.
//   clk_25      : 25 MHz pixel clock
//   reset_n     : asynchronous active-low reset, synchronous release
//   rd          : framebuffer read port (read_addr out, read_data in)
//   hsync/vsync : active-low sync outputs
//   de          : high during the visible 640x480 window
//   pixel_out   : pixel value, 0 outside the visible window
//   frame_start : one-cycle pulse with the output of pixel (0,0)
// All outputs are registered and appear RD_LATENCY+2 cycles after the
// counter position they describe.
module fb_scanout #(
    parameter int ADDR_WIDTH = 15,
    parameter int RD_LATENCY = 1
) (
    input  logic         clk_25,
    input  logic         reset_n,
    fb_scanout_if.master rd,
    output logic         hsync,
    output logic         vsync,
    output logic         de,
    output logic         pixel_out,
    output logic         frame_start
);
    localparam logic [9:0] H_VIS        = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VIS        = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;
    localparam logic [9:0] V_LAST       = 10'd524;

    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
        $error("fb_scanout: RD_LATENCY must be in 1..3");
    end

    logic [9:0]            r_h_cnt;
    logic [9:0]            r_v_cnt;
    logic                  w_vis;
    logic                  w_hsync;
    logic                  w_vsync;
    logic                  w_fs;
    logic [ADDR_WIDTH-1:0] w_y_ext;
    logic [ADDR_WIDTH-1:0] w_x_ext;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_read_addr;
    logic [RD_LATENCY:0]   r_de_dly;
    logic [RD_LATENCY:0]   r_hs_dly;
    logic [RD_LATENCY:0]   r_vs_dly;
    logic [RD_LATENCY:0]   r_fs_dly;
    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_de;
    logic                  r_pixel;
    logic                  r_fs;

    // Raster position counters.
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    always_comb begin
        w_vis   = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
        w_hsync = !((r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_END));
        w_vsync = !((r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_END));
        w_fs    = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
        // Dropping the two LSBs of each counter gives the 4x4 upscale;
        // y*160 is built from two shifts, so no multiplier is needed.
        w_y_ext = ADDR_WIDTH'(r_v_cnt[9:2]);
        w_x_ext = ADDR_WIDTH'(r_h_cnt[9:2]);
        w_addr  = (w_y_ext << 7) + (w_y_ext << 5) + w_x_ext;
    end

    // Address is parked at 0 outside the visible window.
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_read_addr <= '0;
        end else begin
            r_read_addr <= w_vis ? w_addr : '0;
        end
    end

    // Timing signals wait 1+RD_LATENCY cycles so they line up with the
    // returned pixel; the output stage then registers everything together.
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_de_dly <= '0;
            r_hs_dly <= '1;
            r_vs_dly <= '1;
            r_fs_dly <= '0;
        end else begin
            r_de_dly <= {r_de_dly[RD_LATENCY-1:0], w_vis};
            r_hs_dly <= {r_hs_dly[RD_LATENCY-1:0], w_hsync};
            r_vs_dly <= {r_vs_dly[RD_LATENCY-1:0], w_vsync};
            r_fs_dly <= {r_fs_dly[RD_LATENCY-1:0], w_fs};
        end
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_de    <= 1'b0;
            r_pixel <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            r_hsync <= r_hs_dly[RD_LATENCY];
            r_vsync <= r_vs_dly[RD_LATENCY];
            r_de    <= r_de_dly[RD_LATENCY];
            r_pixel <= r_de_dly[RD_LATENCY] & rd.read_data;
            r_fs    <= r_fs_dly[RD_LATENCY];
        end
    end

    assign rd.read_addr = r_read_addr;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign de           = r_de;
    assign pixel_out    = r_pixel;
    assign frame_start  = r_fs;
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: scoreboard bench for fb_scanout with RD_LATENCY 1 and 3
// running side by side from one clock/reset. A reference model derives the
// expected raster outputs from the position index since reset release.
module tb_fb_scanout;
    localparam int AW   = 15;
    localparam int NPIX = 19200;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic px;
        logic fs;
    } vid_t;

    localparam vid_t RST_VID = 5'b11000;

    logic clk_25  = 1'b0;
    logic reset_n = 1'b0;
    bit   mem [NPIX];
    bit   checker_on = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #20 clk_25 = ~clk_25;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mem_at(input int a);
        return (a >= 0 && a < NPIX) ? mem[a] : 1'b0;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_chk
        localparam int LAT     = (g == 0) ? 1 : 3;
        localparam int OUT_LAT = LAT + 2;

        fb_scanout_if #(.ADDR_WIDTH(AW)) rd_if ();
        logic       hs, vs, de, px, fs;
        logic [2:0] ram_pipe = '0;
        vid_t       q_vid[$];
        int         q_addr[$];
        int         fs_total = 0;

        fb_scanout #(.ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
            .clk_25     (clk_25),
            .reset_n    (reset_n),
            .rd         (rd_if),
            .hsync      (hs),
            .vsync      (vs),
            .de         (de),
            .pixel_out  (px),
            .frame_start(fs)
        );

        // Framebuffer with a LAT-deep read pipeline.
        always @(posedge clk_25) ram_pipe <= {ram_pipe[1:0], mem_at(int'(rd_if.read_addr))};
        assign rd_if.read_data = ram_pipe[LAT-1];

        // Reference model: position n since release -> expected outputs.
        initial begin
            int   n;
            int   h, v, a;
            bit   vis;
            vid_t e;
            n = 0;
            forever begin
                @(negedge clk_25);
                #2;
                if (!reset_n) begin
                    q_vid.delete();
                    q_addr.delete();
                    n = 0;
                end else begin
                    if (n == 0) begin
                        repeat (OUT_LAT) q_vid.push_back(RST_VID);
                        q_addr.push_back(0);
                    end
                    h    = n % 800;
                    v    = (n / 800) % 525;
                    vis  = (h < 640) && (v < 480);
                    a    = vis ? (v / 4) * 160 + h / 4 : 0;
                    e.hs = !(h >= 656 && h < 752);
                    e.vs = !(v >= 490 && v < 492);
                    e.de = vis;
                    e.px = vis ? mem_at(a) : 1'b0;
                    e.fs = (n % 420000) == 0;
                    q_vid.push_back(e);
                    q_addr.push_back(a);
                    n++;
                end
            end
        end

        // Monitor: pops one expectation per cycle and compares.
        initial begin
            int   c, ea, since_rise, de_cnt, hs_cnt, hs_fall, p, xx, yy;
            bit   seen_rise, prev_de, prev_hs;
            vid_t got, e;
            c = 0; since_rise = 0; de_cnt = 0; hs_cnt = 0; hs_fall = -1;
            seen_rise = 1'b0; prev_de = 1'b0; prev_hs = 1'b1;
            forever begin
                @(negedge clk_25);
                #3;
                got = {hs, vs, de, px, fs};
                if (!reset_n) begin
                    check($sformatf("rst_vid_L%0d", LAT), int'(got), int'(RST_VID));
                    check($sformatf("rst_addr_L%0d", LAT), int'(rd_if.read_addr), 0);
                    c = 0; seen_rise = 1'b0; prev_de = 1'b0; prev_hs = 1'b1;
                end else begin
                    if (q_vid.size() == 0 || q_addr.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL queue_empty_L%0d: no expectation at cycle %0d", LAT, c);
                    end else begin
                        e  = q_vid.pop_front();
                        ea = q_addr.pop_front();
                        check($sformatf("vid_L%0d c%0d", LAT, c), int'(got), int'(e));
                        check($sformatf("addr_L%0d c%0d", LAT, c), int'(rd_if.read_addr), ea);
                    end
                    if (c >= 1 && c <= 5)
                        check($sformatf("addr_start_L%0d c%0d", LAT, c), int'(rd_if.read_addr), (c == 5) ? 1 : 0);
                    if (c == 3205)
                        check($sformatf("addr_4_4_L%0d", LAT), int'(rd_if.read_addr), 161);
                    if (c == OUT_LAT) begin
                        check($sformatf("fs_first_L%0d", LAT), int'(fs), 1);
                        check($sformatf("de_first_L%0d", LAT), int'(de), 1);
                    end
                    if (fs) fs_total++;
                    if (checker_on && c >= OUT_LAT) begin
                        p  = c - OUT_LAT;
                        xx = p % 800;
                        yy = (p / 800) % 525;
                        if (xx < 640 && yy < 480)
                            check($sformatf("checker_L%0d x%0d y%0d", LAT, xx, yy), int'(px), ((xx >> 2) ^ (yy >> 2)) & 1);
                    end
                    if (de && !prev_de) begin
                        if (seen_rise) begin
                            check($sformatf("line_period_L%0d", LAT), since_rise, 800);
                            check($sformatf("de_width_L%0d", LAT), de_cnt, 640);
                            check($sformatf("hs_width_L%0d", LAT), hs_cnt, 96);
                            check($sformatf("hs_offset_L%0d", LAT), hs_fall, 656);
                        end
                        seen_rise  = 1'b1;
                        since_rise = 0;
                        de_cnt     = 0;
                        hs_cnt     = 0;
                        hs_fall    = -1;
                    end
                    if (de) de_cnt++;
                    if (!hs) hs_cnt++;
                    if (!hs && prev_hs) hs_fall = since_rise;
                    since_rise++;
                    prev_de = de;
                    prev_hs = hs;
                    c++;
                end
            end
        end
    end

    initial begin
        #(40 * 100000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = bit'($urandom_range(0, 1));
        reset_n = 1'b0;
        repeat (4) @(negedge clk_25);
        reset_n = 1'b1;
        // Position 19500 is h=300 on line 24: reset mid-line for 2 cycles.
        repeat (19500) @(negedge clk_25);
        reset_n = 1'b0;
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                mem[y * 160 + x] = bit'((x ^ y) & 1);
        checker_on = 1'b1;
        repeat (2) @(negedge clk_25);
        reset_n = 1'b1;
        repeat (10400 + $urandom_range(0, 799)) @(negedge clk_25);
        reset_n    = 1'b0;
        checker_on = 1'b0;
        for (int i = 0; i < NPIX; i++) mem[i] = bit'($urandom_range(0, 1));
        repeat ($urandom_range(1, 4)) @(negedge clk_25);
        reset_n = 1'b1;
        repeat (16000) @(negedge clk_25);
        #5;
        check("fs_total_L1", g_chk[0].fs_total, 3);
        check("fs_total_L3", g_chk[1].fs_total, 3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Read side of the 160x120 monochrome framebuffer; the filler is the write side.
- Generates 640x480@60 VGA timing from clk_25.
- Fetches framebuffer pixels over a synchronous read port, upscaling each stored pixel 4x horizontally and 4x vertically.
- Drives hsync, vsync, data-enable and the pixel stream to the DAC/pin stage.

Parameters:
- ADDR_WIDTH, 15, framebuffer address width (QQVGA 160x120 = 19200 words, fits in 2^15).
- RD_LATENCY, 1, cycles from read_addr change to matching read_data; legal range 1..3.

Ports:
- clk_25  input  1  25 MHz pixel clock; single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- read_addr  output  ADDR_WIDTH  framebuffer read address.
- read_data  input  1  framebuffer pixel, valid RD_LATENCY cycles after read_addr.
- hsync  output  1  horizontal sync, active low.
- vsync  output  1  vertical sync, active low.
- de  output  1  high during visible 640x480 region.
- pixel_out  output  1  pixel value; forced 0 when de=0.
- frame_start  output  1  one-cycle pulse coincident with output of visible pixel (0,0).

Behaviour:
- Reset (async assert, sync release): h_cnt=0, v_cnt=0, all pipeline stages cleared.
  - Outputs at reset: read_addr=0, hsync=1, vsync=1, de=0, pixel_out=0, frame_start=0.
- h_cnt counts 0..799 and increments every cycle.
  - At 799 it wraps to 0 and v_cnt increments.
  - v_cnt counts 0..524; wraps to 0 when h_cnt=799 and v_cnt=524.
- Horizontal timing: visible 0..639, front porch 640..655, sync 656..751 (hsync=0), back porch 752..799.
- Vertical timing: visible 0..479, front porch 480..489, sync 490..491 (vsync=0), back porch 492..524.
- Stage A (counter position at cycle t): vis = (h_cnt<640) && (v_cnt<480).
- Address:
  - read_addr registered at end of cycle t: (v_cnt>>2)*160 + (h_cnt>>2) if vis, else 0.
  - Multiply by 160 is implemented as (y<<7)+(y<<5); no multiplier.
  - Maximum address is 19199; no overflow.
- Data return: read_data belonging to position t is sampled at the end of cycle t+1+RD_LATENCY.
- Sync/enable alignment: hsync/vsync/de/frame_start for position t pass through a delay line of 1+RD_LATENCY registers so they align with the sampled data.
  - All outputs are registered and appear together.
  - Total latency from counter position to outputs = RD_LATENCY+2 cycles; with the default this is 3.
- pixel_out = read_data when delayed de=1, else 0.
- frame_start = 1 only for the output cycle of position (h=0, v=0).
- Each framebuffer address is issued on 4 consecutive cycles per line and repeated for 4 consecutive lines. No caching; the RAM is read every visible cycle.
- Frame period: exactly 800*525 = 420000 cycles, with no gaps.
- Reset mid-frame: all state clears immediately.
  - Outputs hold reset values until pipeline refill.
  - First frame_start occurs RD_LATENCY+2 cycles after reset release; default 3.
- No backpressure or handshake: the reader is the timing master, and read_data is assumed valid per RD_LATENCY.

Test Plan:
- Release reset at cycle 0 (RD_LATENCY=1) with RAM model returning (addr[0]) -> frame_start=1 and de=1 at cycle 3; read_addr at cycles 1..4 = 0,0,0,0 then 1 at cycle 5.
- Count hsync over one line -> low for exactly 96 cycles, beginning 656 cycles after de rises; period 800 cycles; de high 640 cycles per line.
- Count vsync over one frame -> low for exactly 2 lines (1600 cycles), asserted at the start of line 490; frame_start interval = 420000 cycles; 480 lines with de activity.
- Scaling check: at position (h=639, v=479) read_addr=19199; at (h=4, v=4) read_addr=161; at h>=640 read_addr=0.
- Fill RAM with a checkerboard (pixel = x^y LSB) -> every output pixel at (X,Y) equals ((X>>2)^(Y>>2))&1; pixel_out=0 whenever de=0.
- Assert reset_n low at h=300, v=200 for 2 cycles -> outputs return to reset values within the same cycle; timing restarts; frame_start 3 cycles after release; rerun with RD_LATENCY=3 -> latency 5, alignment preserved.
